// File: rtl/ps2_key_tx.sv
// ps2_key_tx: keyboard-emulation transmitter. Accepts one ASCII byte per
// valid/ready handshake, maps it to its PS/2 Set-2 scan code and sends
// make + break (code, F0, code) as device-side PS/2 frames.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   ascii, ascii_valid  character in, sampled on handshake
//   ascii_ready         high only while idle
//   ps2_clk, ps2_data   PS/2 lines towards the receiver (idle high)
//   busy                high from the cycle after acceptance until idle again
//   unmapped            one-cycle pulse when an accepted character has no code
module ps2_key_tx #(
    parameter int unsigned CLK_DIV = 2500,
    parameter int unsigned GAP     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       unmapped
);

    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned FRM_W     = 11;
    localparam int unsigned LAST_CELL = 10;
    localparam logic [7:0]  BREAK     = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // ASCII -> Set-2 scan code; bit 8 flags a valid mapping.
    function automatic logic [8:0] map_ascii(input logic [7:0] a);
        logic [8:0] m;
        m = 9'h000;
        case (a)
            8'h61: m = 9'h11C;  8'h62: m = 9'h132;  8'h63: m = 9'h121;  8'h64: m = 9'h123;
            8'h65: m = 9'h124;  8'h66: m = 9'h12B;  8'h67: m = 9'h134;  8'h68: m = 9'h133;
            8'h69: m = 9'h143;  8'h6A: m = 9'h13B;  8'h6B: m = 9'h142;  8'h6C: m = 9'h14B;
            8'h6D: m = 9'h13A;  8'h6E: m = 9'h131;  8'h6F: m = 9'h144;  8'h70: m = 9'h14D;
            8'h71: m = 9'h115;  8'h72: m = 9'h12D;  8'h73: m = 9'h11B;  8'h74: m = 9'h12C;
            8'h75: m = 9'h13C;  8'h76: m = 9'h12A;  8'h77: m = 9'h11D;  8'h78: m = 9'h122;
            8'h79: m = 9'h135;  8'h7A: m = 9'h11A;
            8'h30: m = 9'h145;  8'h31: m = 9'h116;  8'h32: m = 9'h11E;  8'h33: m = 9'h126;
            8'h34: m = 9'h125;  8'h35: m = 9'h12E;  8'h36: m = 9'h136;  8'h37: m = 9'h13D;
            8'h38: m = 9'h13E;  8'h39: m = 9'h146;
            8'h2D: m = 9'h14E;  8'h3D: m = 9'h155;  8'h60: m = 9'h10E;  8'h5B: m = 9'h154;
            8'h5D: m = 9'h15B;  8'h3B: m = 9'h14C;  8'h27: m = 9'h152;  8'h2C: m = 9'h141;
            8'h2E: m = 9'h149;  8'h2F: m = 9'h14A;  8'h5C: m = 9'h15D;  8'h20: m = 9'h129;
            8'h0D: m = 9'h15A;  8'h08: m = 9'h166;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_ascii, w_ascii_nxt;
    logic [7:0]         r_code, w_code_nxt;
    logic [FRM_W-1:0]   r_frame, w_frame_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic               r_half, w_half_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [1:0]         r_byte_idx, w_byte_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_unmapped, w_unmapped_nxt;
    logic               r_ps2_clk, w_clk_nxt;
    logic               r_ps2_data, w_data_nxt;
    logic [8:0]         w_map;
    logic               w_load;
    logic [7:0]         w_load_byte;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ascii    <= '0;
            r_code     <= '0;
            r_frame    <= '0;
            r_div      <= '0;
            r_half     <= 1'b0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_byte_idx <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_unmapped <= 1'b0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ascii    <= w_ascii_nxt;
            r_code     <= w_code_nxt;
            r_frame    <= w_frame_nxt;
            r_div      <= w_div_nxt;
            r_half     <= w_half_nxt;
            r_bit      <= w_bit_nxt;
            r_gap      <= w_gap_nxt;
            r_byte_idx <= w_byte_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_unmapped <= w_unmapped_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ascii_nxt    = r_ascii;
        w_code_nxt     = r_code;
        w_frame_nxt    = r_frame;
        w_div_nxt      = r_div;
        w_half_nxt     = r_half;
        w_bit_nxt      = r_bit;
        w_gap_nxt      = r_gap;
        w_byte_nxt     = r_byte_idx;
        w_ready_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_unmapped_nxt = 1'b0;
        w_clk_nxt      = r_ps2_clk;
        w_data_nxt     = r_ps2_data;
        w_map          = map_ascii(r_ascii);
        w_load         = 1'b0;
        w_load_byte    = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (ascii_valid && r_ready) begin
                    w_ascii_nxt = ascii;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_LOOKUP;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (!w_map[8]) begin
                    w_unmapped_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_ready_nxt    = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_code_nxt  = w_map[7:0];
                    w_byte_nxt  = 2'd0;
                    w_load      = 1'b1;
                    w_load_byte = w_map[7:0];
                end
            end
            S_FRAME: begin
                // Each cell: CLK_DIV cycles clock high, then CLK_DIV cycles low.
                if (r_div == DIV_W'(CLK_DIV - 1)) begin
                    w_div_nxt = '0;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                        w_clk_nxt  = 1'b0;
                    end else begin
                        w_half_nxt = 1'b0;
                        w_clk_nxt  = 1'b1;
                        if (r_bit == BIT_W'(LAST_CELL)) begin
                            w_data_nxt  = 1'b1;
                            w_gap_nxt   = '0;
                            w_state_nxt = S_GAP;
                        end else begin
                            // Data only moves together with the rising clock.
                            w_bit_nxt   = r_bit + BIT_W'(1);
                            w_frame_nxt = {1'b1, r_frame[FRM_W-1:1]};
                            w_data_nxt  = r_frame[1];
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(GAP - 1)) begin
                    w_gap_nxt = '0;
                    case (r_byte_idx)
                        2'd0: begin
                            w_byte_nxt  = 2'd1;
                            w_load      = 1'b1;
                            w_load_byte = BREAK;
                        end
                        2'd1: begin
                            w_byte_nxt  = 2'd2;
                            w_load      = 1'b1;
                            w_load_byte = r_code;
                        end
                        default: begin
                            w_busy_nxt  = 1'b0;
                            w_ready_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Frame start: {stop, odd parity, data, start}, start bit driven first.
        if (w_load) begin
            w_frame_nxt = {1'b1, ~^w_load_byte, w_load_byte, 1'b0};
            w_div_nxt   = '0;
            w_half_nxt  = 1'b0;
            w_bit_nxt   = '0;
            w_gap_nxt   = '0;
            w_clk_nxt   = 1'b1;
            w_data_nxt  = 1'b0;
            w_state_nxt = S_FRAME;
        end
    end

    assign ascii_ready = r_ready;
    assign busy        = r_busy;
    assign unmapped    = r_unmapped;
    assign ps2_clk     = r_ps2_clk;
    assign ps2_data    = r_ps2_data;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Self-checking bench for ps2_key_tx: one instance at CLK_DIV=4/GAP=8 for
// directed tests, one at CLK_DIV=2/GAP=1 for the full round-trip sweep.
`timescale 1ns/1ps
module tb_ps2_key_tx;

    localparam int N_MAP = 50;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic       ascii_valid = 1'b0;
    logic       ascii_ready, ps2_clk, ps2_data, busy, unmapped;
    logic [7:0] f_ascii = 8'h00;
    logic       f_valid = 1'b0;
    logic       f_ready, f_ps2_clk, f_ps2_data, f_busy, f_unmapped;

    always #5 clk = ~clk;

    ps2_key_tx #(.CLK_DIV(4), .GAP(8)) u_dut (
        .clk(clk), .rst(rst), .ascii(ascii), .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .busy(busy), .unmapped(unmapped)
    );

    ps2_key_tx #(.CLK_DIV(2), .GAP(1)) u_dut_fast (
        .clk(clk), .rst(rst), .ascii(f_ascii), .ascii_valid(f_valid),
        .ascii_ready(f_ready), .ps2_clk(f_ps2_clk), .ps2_data(f_ps2_data),
        .busy(f_busy), .unmapped(f_unmapped)
    );

    // Character set and its scan codes, as a receive-side lookup table.
    logic [7:0] map_a [N_MAP] = '{
        8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A,
        8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74,
        8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A,
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h2D, 8'h3D, 8'h60, 8'h5B, 8'h5D, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F,
        8'h5C, 8'h20, 8'h0D, 8'h08};
    logic [7:0] map_s [N_MAP] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h4E, 8'h55, 8'h0E, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A,
        8'h5D, 8'h29, 8'h5A, 8'h66};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] s);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < N_MAP; i++)
            if (map_s[i] == s) a = map_a[i];
        return a;
    endfunction

    // Line monitor / PS/2 receiver state.
    logic [10:0] rx_q [$];
    logic [10:0] rx_sh = '0, f_sh = '0;
    int          rx_cnt = 0, f_rx_cnt = 0;
    int          rx_bad = 0, f_rx_bad = 0, f_n_frm = 0;
    int          n_fall = 0, n_low = 0, n_unstable = 0, n_rdy_edge = 0, n_acc = 0;
    logic [7:0]  f_rec [$];
    logic        f_brk = 1'b0;
    logic        p_clk = 1'b1, p_data = 1'b1, fp_clk = 1'b1, fp_data = 1'b1;
    logic        hs;

    // Samples both DUTs 1 ns after each edge; receivers shift on ps2_clk falls.
    always begin
        @(posedge clk);
        hs = ascii_ready && ascii_valid && !rst;
        #1;
        if (hs) n_acc++;
        if (rst) begin
            rx_cnt   = 0;
            f_rx_cnt = 0;
            f_brk    = 1'b0;
        end else begin
            if (p_clk && !ps2_clk) begin
                rx_sh = {ps2_data, rx_sh[10:1]};
                rx_cnt++;
                n_fall++;
                if (rx_cnt == 11) begin
                    rx_q.push_back(rx_sh);
                    if (!frame_ok(rx_sh)) rx_bad++;
                    rx_cnt = 0;
                end
            end
            if (!p_clk && !ps2_clk && (ps2_data != p_data)) n_unstable++;
            if (ascii_ready && ((ps2_clk != p_clk) || (ps2_data != p_data))) n_rdy_edge++;
            if (!ps2_clk) n_low++;

            if (fp_clk && !f_ps2_clk) begin
                f_sh = {f_ps2_data, f_sh[10:1]};
                f_rx_cnt++;
                if (f_rx_cnt == 11) begin
                    f_n_frm++;
                    if (!frame_ok(f_sh)) f_rx_bad++;
                    if (f_sh[8:1] == 8'hF0) f_brk = 1'b1;
                    else if (f_brk) f_brk = 1'b0;
                    else f_rec.push_back(scan_to_ascii(f_sh[8:1]));
                    f_rx_cnt = 0;
                end
            end
            if (!fp_clk && !f_ps2_clk && (f_ps2_data != fp_data)) n_unstable++;
            if (f_ready && ((f_ps2_clk != fp_clk) || (f_ps2_data != fp_data))) n_rdy_edge++;
        end
        p_clk   = ps2_clk;
        p_data  = ps2_data;
        fp_clk  = f_ps2_clk;
        fp_data = f_ps2_data;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < LIMIT; k++) begin
            if (ascii_ready) break;
            tick();
        end
        check(tag, 32'(ascii_ready), 1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready("send_ready");
        ascii       = c;
        ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
    endtask

    function automatic logic [31:0] pop_frame();
        if (rx_q.size() == 0) return 32'hDEAD;
        return 32'(rx_q.pop_front());
    endfunction

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state.
        #1 rst = 1'b1;
        tick(); tick();
        check("rst_ps2_clk", 32'(ps2_clk), 1);
        check("rst_ps2_data", 32'(ps2_data), 1);
        check("rst_ready", 32'(ascii_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_unmapped", 32'(unmapped), 0);
        rst = 1'b0;
        tick();
        check("ready_first_edge", 32'(ascii_ready), 1);
        check("fast_ready_first_edge", 32'(f_ready), 1);

        // Test 1: 'a' -> 1C, F0, 1C.
        rx_q.delete(); n_low = 0; n_fall = 0;
        send(8'h61);
        check("t1_busy_acc", 32'(busy), 1);
        check("t1_ready_acc", 32'(ascii_ready), 0);
        tick();
        check("t1_start_bit", 32'(ps2_data), 0);
        check("t1_clk_high", 32'(ps2_clk), 1);
        check("t1_busy_next", 32'(busy), 1);
        cnt = 2;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            if (!busy) break;
            cnt++;
        end
        check("t1_busy_cycles", 32'(cnt), 289);
        check("t1_ready_back", 32'(ascii_ready), 1);
        check("t1_frames", 32'(rx_q.size()), 3);
        check("t1_f0_1C", pop_frame(), 32'h438);
        check("t1_f1_F0", pop_frame(), 32'h7E0);
        check("t1_f2_1C", pop_frame(), 32'h438);
        check("t1_clk_low_cycles", 32'(n_low), 132);
        check("t1_clk_falls", 32'(n_fall), 33);

        // Test 2: unmapped characters.
        send(8'h41);
        check("t2A_busy", 32'(busy), 1);
        check("t2A_unmapped_early", 32'(unmapped), 0);
        tick();
        check("t2A_unmapped", 32'(unmapped), 1);
        check("t2A_ready", 32'(ascii_ready), 1);
        check("t2A_busy_low", 32'(busy), 0);
        tick();
        check("t2A_unmapped_clr", 32'(unmapped), 0);
        send(8'hFF);
        tick();
        check("t2FF_unmapped", 32'(unmapped), 1);
        check("t2FF_ready", 32'(ascii_ready), 1);
        tick();
        check("t2FF_unmapped_clr", 32'(unmapped), 0);
        check("t2_no_frames", 32'(rx_q.size()), 0);
        check("t2_lines_idle", {30'd0, ps2_clk, ps2_data}, 32'h3);

        // Test 3: back-to-back with valid held; ascii scribbled while busy.
        rx_q.delete();
        cnt = n_acc;
        ascii_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready("t3_ready");
            ascii = (i == 0) ? 8'h0D : (i == 1) ? 8'h08 : 8'h5C;
            tick();
            ascii = 8'h61;
            if (i == 2) ascii_valid = 1'b0;
        end
        wait_ready("t3_done");
        check("t3_accepts", 32'(n_acc - cnt), 3);
        check("t3_f0", pop_frame(), 32'h6B4);
        check("t3_f1", pop_frame(), 32'h7E0);
        check("t3_f2", pop_frame(), 32'h6B4);
        check("t3_f3", pop_frame(), 32'h6CC);
        check("t3_f4", pop_frame(), 32'h7E0);
        check("t3_f5", pop_frame(), 32'h6CC);
        check("t3_f6", pop_frame(), 32'h4BA);
        check("t3_f7", pop_frame(), 32'h7E0);
        check("t3_f8", pop_frame(), 32'h4BA);
        check("t3_no_extra", 32'(rx_q.size()), 0);

        // Test 4: reset during the low half of the F0 parity cell.
        rx_q.delete();
        send(8'h61);
        for (int k = 0; k < LIMIT; k++) begin
            if (rx_q.size() == 1 && rx_cnt == 10) break;
            tick();
        end
        check("t4_in_parity_low", 32'(ps2_clk), 0);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_clk", 32'(ps2_clk), 1);
        check("t4_rst_data", 32'(ps2_data), 1);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_ready", 32'(ascii_ready), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t4_ready_after_rst", 32'(ascii_ready), 1);
        rx_q.delete();
        send(8'h7A);
        wait_ready("t4_done");
        check("t4_f0_1A", pop_frame(), 32'h434);
        check("t4_f1_F0", pop_frame(), 32'h7E0);
        check("t4_f2_1A", pop_frame(), 32'h434);
        check("t4_no_extra", 32'(rx_q.size()), 0);

        // Test 5: round-trip sweep on the fast instance.
        f_n_frm = 0;
        for (int i = 0; i < N_MAP; i++) begin
            f_rec.delete();
            for (int k = 0; k < LIMIT && !f_ready; k++) tick();
            f_ascii = map_a[i];
            f_valid = 1'b1;
            tick();
            f_valid = 1'b0;
            tick();
            for (int k = 0; k < LIMIT && !f_ready; k++) tick();
            check($sformatf("t5_roundtrip_%02h", map_a[i]),
                  (f_rec.size() == 1) ? 32'(f_rec[0]) : 32'hDEAD, 32'(map_a[i]));
        end
        check("t5_frame_count", 32'(f_n_frm), 32'(3 * N_MAP));

        check("frame_format", 32'(rx_bad + f_rx_bad), 0);
        check("data_stable_clk_low", 32'(n_unstable), 0);
        check("no_edges_while_ready", 32'(n_rdy_edge), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
